// File: rtl/fsic_io_serdes_tx_framer.sv
// FSIC IO serdes transmit framer: FIFO-buffered stream words serialised over
// pCLK_RATIO ioclk cycles, with link training, credit flow control and parity.

module fsic_io_serdes_tx_framer #(
    parameter int pDATA_WIDTH   = 32,
    parameter int pCLK_RATIO    = 4,
    parameter int pTxFIFO_DEPTH = 4,
    parameter int pCREDIT_WIDTH = 4,
    parameter int pINIT_CREDIT  = 4,
    parameter int pTRAIN_FRAMES = 8,
    localparam int pLANES = pDATA_WIDTH / pCLK_RATIO,
    localparam int PW     = $clog2(pCLK_RATIO),
    localparam int AW     = $clog2(pTxFIFO_DEPTH)
) (
    input  logic                     ioclk,
    input  logic                     ioclk_rst,
    input  logic                     txen,
    input  logic [pDATA_WIDTH-1:0]   in_tdata,
    input  logic                     in_tlast,
    input  logic                     in_tvalid,
    output logic                     in_tready,
    input  logic                     credit_return,
    output logic [pLANES-1:0]        serial_txd,
    output logic                     serial_tctl,
    output logic                     serial_tclk_en,
    output logic [PW-1:0]            phase_out,
    output logic [1:0]               link_state,
    output logic [pCREDIT_WIDTH-1:0] credit_cnt,
    output logic [AW:0]              fifo_level,
    output logic                     credit_ovf
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        TRAIN = 2'd1,
        RUN   = 2'd2
    } state_t;

    localparam int LW  = AW + 1;
    localparam int TCW = $clog2(pTRAIN_FRAMES + 1);
    localparam int CW  = pCREDIT_WIDTH;

    localparam logic [pCLK_RATIO-1:0] TRAIN_CTL  = pCLK_RATIO'(2);
    localparam logic [PW-1:0]         LAST_PHASE = PW'(pCLK_RATIO - 1);
    localparam logic [TCW-1:0]        LAST_TRAIN = TCW'(pTRAIN_FRAMES - 1);
    localparam logic [LW-1:0]         FULL_LEVEL = LW'(pTxFIFO_DEPTH);

    // Frame held lane-major: frame[j][p] is the bit lane j drives at phase p,
    // which is exactly data[j*R+p] when a word is loaded unchanged.
    typedef logic [pLANES-1:0][pCLK_RATIO-1:0] frame_t;

    state_t                  state, state_nxt;
    logic [PW-1:0]           phase, phase_nxt;
    frame_t                  frame, frame_nxt, train_frame, run_frame;
    logic [pCLK_RATIO-1:0]   fctl, fctl_nxt, run_ctl;
    logic [TCW-1:0]          tcnt, tcnt_nxt;

    logic [pDATA_WIDTH:0]    mem [pTxFIFO_DEPTH];
    logic [AW-1:0]           wr_ptr, rd_ptr;
    logic [LW-1:0]           level;
    logic [CW-1:0]           credits;

    logic                    push, pop, can_send, frame_end;
    logic [pDATA_WIDTH-1:0]  head_data;
    logic                    head_last;

    assign in_tready = (level != FULL_LEVEL);
    assign push      = in_tvalid && in_tready;
    assign can_send  = (level != '0) && (credits != '0);
    assign frame_end = (phase == LAST_PHASE);
    assign head_data = mem[rd_ptr][pDATA_WIDTH-1:0];
    assign head_last = mem[rd_ptr][pDATA_WIDTH];

    always_comb begin
        train_frame = '0;
        for (int unsigned j = 0; j < pLANES; j++) begin
            train_frame[j] = pCLK_RATIO'(1);
        end
    end

    always_comb begin
        run_frame = '0;
        run_ctl   = '0;
        if (can_send) begin
            run_frame  = head_data;
            run_ctl[0] = 1'b1;
            run_ctl[1] = head_last;
            run_ctl[2] = ^head_data;
        end
    end

    always_comb begin
        state_nxt = state;
        phase_nxt = phase + 1'b1;
        frame_nxt = frame;
        fctl_nxt  = fctl;
        tcnt_nxt  = tcnt;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                phase_nxt = '0;
                if (txen) begin
                    state_nxt = TRAIN;
                    frame_nxt = train_frame;
                    fctl_nxt  = TRAIN_CTL;
                    tcnt_nxt  = '0;
                end
            end
            TRAIN: begin
                if (frame_end) begin
                    if (!txen) begin
                        state_nxt = IDLE;
                        frame_nxt = '0;
                        fctl_nxt  = '0;
                    end else if (tcnt == LAST_TRAIN) begin
                        state_nxt = RUN;
                        frame_nxt = run_frame;
                        fctl_nxt  = run_ctl;
                        pop       = can_send;
                    end else begin
                        tcnt_nxt  = tcnt + 1'b1;
                        frame_nxt = train_frame;
                        fctl_nxt  = TRAIN_CTL;
                    end
                end
            end
            RUN: begin
                if (frame_end) begin
                    if (!txen) begin
                        state_nxt = IDLE;
                        frame_nxt = '0;
                        fctl_nxt  = '0;
                    end else begin
                        frame_nxt = run_frame;
                        fctl_nxt  = run_ctl;
                        pop       = can_send;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                phase_nxt = '0;
                frame_nxt = '0;
                fctl_nxt  = '0;
            end
        endcase
    end

    always_ff @(posedge ioclk or posedge ioclk_rst) begin
        if (ioclk_rst) begin
            state <= IDLE;
            phase <= '0;
            frame <= '0;
            fctl  <= '0;
            tcnt  <= '0;
        end else begin
            state <= state_nxt;
            phase <= phase_nxt;
            frame <= frame_nxt;
            fctl  <= fctl_nxt;
            tcnt  <= tcnt_nxt;
        end
    end

    // Storage is not reset; occupancy and pointers define what is valid.
    always_ff @(posedge ioclk) begin
        if (push) begin
            mem[wr_ptr] <= {in_tlast, in_tdata};
        end
    end

    always_ff @(posedge ioclk or posedge ioclk_rst) begin
        if (ioclk_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    always_ff @(posedge ioclk or posedge ioclk_rst) begin
        if (ioclk_rst) begin
            credits    <= CW'(pINIT_CREDIT);
            credit_ovf <= 1'b0;
        end else if (pop && !credit_return) begin
            credits <= credits - 1'b1;
        end else if (!pop && credit_return) begin
            if (credits == '1) begin
                credit_ovf <= 1'b1;
            end else begin
                credits <= credits + 1'b1;
            end
        end
    end

    always_comb begin
        serial_txd = '0;
        for (int unsigned j = 0; j < pLANES; j++) begin
            serial_txd[j] = frame[j][phase];
        end
    end

    assign serial_tctl    = fctl[phase];
    assign serial_tclk_en = (state != IDLE);
    assign phase_out      = phase;
    assign link_state     = state;
    assign credit_cnt     = credits;
    assign fifo_level     = level;

endmodule

// File: tb/tb_fsic_io_serdes_tx_framer.sv
// Self-checking bench for fsic_io_serdes_tx_framer: vector tables for training
// and credit arithmetic, a frame-reassembling scoreboard for data words.

module tb_fsic_io_serdes_tx_framer;

    localparam int R     = 4;
    localparam int LANES = 8;

    logic        ioclk = 1'b0;
    logic        ioclk_rst;
    logic        txen;
    logic [31:0] in_tdata;
    logic        in_tlast;
    logic        in_tvalid;
    logic        in_tready;
    logic        credit_return;
    logic [7:0]  serial_txd;
    logic        serial_tctl;
    logic        serial_tclk_en;
    logic [1:0]  phase_out;
    logic [1:0]  link_state;
    logic [3:0]  credit_cnt;
    logic [2:0]  fifo_level;
    logic        credit_ovf;

    int tests = 0;
    int fails = 0;

    fsic_io_serdes_tx_framer #(
        .pDATA_WIDTH  (32),
        .pCLK_RATIO   (4),
        .pTxFIFO_DEPTH(4),
        .pCREDIT_WIDTH(4),
        .pINIT_CREDIT (4),
        .pTRAIN_FRAMES(8)
    ) dut (
        .ioclk         (ioclk),
        .ioclk_rst     (ioclk_rst),
        .txen          (txen),
        .in_tdata      (in_tdata),
        .in_tlast      (in_tlast),
        .in_tvalid     (in_tvalid),
        .in_tready     (in_tready),
        .credit_return (credit_return),
        .serial_txd    (serial_txd),
        .serial_tctl   (serial_tctl),
        .serial_tclk_en(serial_tclk_en),
        .phase_out     (phase_out),
        .link_state    (link_state),
        .credit_cnt    (credit_cnt),
        .fifo_level    (fifo_level),
        .credit_ovf    (credit_ovf)
    );

    always #5 ioclk = ~ioclk;

    typedef struct { logic [31:0] d; logic l; } exp_t;
    typedef struct { logic [7:0] txd; logic ctl; } tvec_t;
    typedef struct { logic ret; logic [3:0] cnt; logic ovf; } cvec_t;

    exp_t  sb[$];
    int    frames_started = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge ioclk);
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst_tready",  32'(in_tready),      32'd1);
        chk("rst_txd",     32'(serial_txd),     32'd0);
        chk("rst_tctl",    32'(serial_tctl),    32'd0);
        chk("rst_tclk_en", 32'(serial_tclk_en), 32'd0);
        chk("rst_phase",   32'(phase_out),      32'd0);
        chk("rst_state",   32'(link_state),     32'd0);
        chk("rst_credit",  32'(credit_cnt),     32'd4);
        chk("rst_level",   32'(fifo_level),     32'd0);
        chk("rst_ovf",     32'(credit_ovf),     32'd0);
    endtask

    task automatic push_word(input logic [31:0] d, input logic l);
        int   n;
        exp_t e;
        n = 0;
        while (!in_tready && n < 60) begin
            tick();
            n++;
        end
        chk("push_ready", 32'(in_tready), 32'd1);
        in_tvalid = 1'b1;
        in_tdata  = d;
        in_tlast  = l;
        e.d = d;
        e.l = l;
        sb.push_back(e);
        tick();
        in_tvalid = 1'b0;
    endtask

    task automatic wait_start(input int limit, output int n);
        n = 0;
        while (!(link_state == 2'd2 && phase_out == 2'd0 && serial_tctl === 1'b1) && n < limit) begin
            tick();
            n++;
        end
        chk("data_start", 32'(link_state == 2'd2 && phase_out == 2'd0 && serial_tctl === 1'b1), 32'd1);
    endtask

    task automatic wait_phase(input logic [1:0] p);
        int n;
        n = 0;
        while (phase_out != p && n < 8) begin
            tick();
            n++;
        end
        chk("wait_phase", 32'(phase_out), 32'(p));
    endtask

    // Reassembles each data frame from the lanes and compares with the queue head.
    initial begin : monitor
        int          mcnt;
        logic [31:0] mword;
        logic [3:0]  mctl;
        exp_t        me;
        mcnt = 0;
        mword = '0;
        mctl = '0;
        forever begin
            @(negedge ioclk);
            if (ioclk_rst) begin
                mcnt = 0;
            end else if (mcnt == 0) begin
                if (link_state == 2'd2 && phase_out == 2'd0 && serial_tctl === 1'b1) begin
                    frames_started++;
                    mword = '0;
                    mctl  = '0;
                    for (int j = 0; j < LANES; j++) mword[j*R] = serial_txd[j];
                    mctl[0] = serial_tctl;
                    mcnt = 1;
                end
            end else begin
                chk("mon_phase", 32'(phase_out), 32'(mcnt));
                for (int j = 0; j < LANES; j++) mword[j*R+mcnt] = serial_txd[j];
                mctl[mcnt] = serial_tctl;
                mcnt++;
                if (mcnt == R) begin
                    mcnt = 0;
                    if (sb.size() == 0) begin
                        chk("sb_underflow", 32'd1, 32'd0);
                    end else begin
                        me = sb.pop_front();
                        chk("frame_data", mword, me.d);
                        chk("frame_ctl", 32'(mctl), 32'({1'b0, ^me.d, me.l, 1'b1}));
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1);
    end

    initial begin : stim
        tvec_t       ttab[R];
        cvec_t       ctab[13];
        logic [3:0]  l0, l1, l7, lc;
        logic [2:0]  lvl;
        int          n, base;

        ttab[0] = '{8'hFF, 1'b0};
        ttab[1] = '{8'h00, 1'b1};
        ttab[2] = '{8'h00, 1'b0};
        ttab[3] = '{8'h00, 1'b0};
        for (int i = 0; i < 11; i++) ctab[i] = '{1'b1, 4'(5 + i), 1'b0};
        ctab[11] = '{1'b1, 4'd15, 1'b1};
        ctab[12] = '{1'b0, 4'd15, 1'b1};

        ioclk_rst = 1'b1;
        txen = 1'b0;
        in_tvalid = 1'b0;
        in_tdata = '0;
        in_tlast = 1'b0;
        credit_return = 1'b0;
        tick();
        tick();
        check_reset_vals();
        ioclk_rst = 1'b0;
        tick();

        // Training: 32 cycles of fixed pattern, RUN after edge e0+32.
        txen = 1'b1;
        tick();
        for (int i = 0; i < 32; i++) begin
            chk("train_txd",   32'(serial_txd),  32'(ttab[i%R].txd));
            chk("train_ctl",   32'(serial_tctl), 32'(ttab[i%R].ctl));
            chk("train_state", 32'(link_state),  32'd1);
            chk("train_phase", 32'(phase_out),   32'(i % R));
            tick();
        end
        chk("run_state",   32'(link_state),     32'd2);
        chk("run_tclk_en", 32'(serial_tclk_en), 32'd1);
        chk("run_idle",    32'(serial_txd),     32'd0);

        // Single data frame with explicit lane patterns.
        push_word(32'h89AB_CDEF, 1'b1);
        wait_start(8, n);
        chk("latency", 32'(n >= 1 && n <= R), 32'd1);
        chk("credit_dec", 32'(credit_cnt), 32'd3);
        l0 = 4'b1111;
        l1 = 4'b1110;
        l7 = 4'b1000;
        lc = 4'b0011;
        for (int p = 0; p < R; p++) begin
            chk("lane0", 32'(serial_txd[0]), 32'(l0[p]));
            chk("lane1", 32'(serial_txd[1]), 32'(l1[p]));
            chk("lane7", 32'(serial_txd[7]), 32'(l7[p]));
            chk("ctl",   32'(serial_tctl),   32'(lc[p]));
            tick();
        end

        // Asynchronous reset in the middle of a data frame.
        push_word(32'h1234_5678, 1'b0);
        wait_start(8, n);
        tick();
        #3;
        ioclk_rst = 1'b1;
        #1;
        check_reset_vals();
        sb.delete();
        tick();
        ioclk_rst = 1'b0;
        n = 0;
        while (link_state != 2'd2 && n < 40) begin
            tick();
            n++;
        end
        chk("retrain_run", 32'(link_state), 32'd2);

        // Credit stall: six words, four credits.
        base = frames_started;
        for (int k = 0; k < 6; k++) push_word(32'hC0DE_0000 | (32'(k) * 32'h0101_1111), 1'(k));
        repeat (30) tick();
        chk("stall_frames", 32'(frames_started - base), 32'd4);
        chk("stall_level",  32'(fifo_level), 32'd2);
        chk("stall_credit", 32'(credit_cnt), 32'd0);
        repeat (R) begin
            chk("stall_idle_ctl", 32'(serial_tctl), 32'd0);
            tick();
        end
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        wait_start(8, n);
        chk("resume_credit", 32'(credit_cnt), 32'd0);
        chk("resume_level",  32'(fifo_level), 32'd1);
        repeat (R) tick();
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        wait_start(8, n);
        repeat (R) tick();
        chk("drain_level", 32'(fifo_level), 32'd0);

        // Credit return on the same edge as a pop.
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("one_credit", 32'(credit_cnt), 32'd1);
        push_word(32'h0F0F_0001, 1'b1);
        wait_phase(2'd3);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        chk("same_edge_start", 32'(link_state == 2'd2 && phase_out == 2'd0 && serial_tctl === 1'b1), 32'd1);
        chk("same_edge_credit", 32'(credit_cnt), 32'd1);
        repeat (R) tick();

        // Disable mid-frame; FIFO contents survive IDLE.
        push_word(32'hB00B_0002, 1'b0);
        push_word(32'hC00C_0003, 1'b1);
        wait_start(8, n);
        wait_phase(2'd1);
        lvl = fifo_level;
        chk("dis_level_pre", 32'(lvl), 32'd1);
        txen = 1'b0;
        tick();
        chk("dis_phase2", 32'(phase_out),  32'd2);
        chk("dis_state2", 32'(link_state), 32'd2);
        tick();
        chk("dis_phase3", 32'(phase_out),  32'd3);
        chk("dis_state3", 32'(link_state), 32'd2);
        tick();
        chk("dis_state",   32'(link_state),     32'd0);
        chk("dis_phase",   32'(phase_out),      32'd0);
        chk("dis_txd",     32'(serial_txd),     32'd0);
        chk("dis_tctl",    32'(serial_tctl),    32'd0);
        chk("dis_tclk_en", 32'(serial_tclk_en), 32'd0);
        chk("dis_level",   32'(fifo_level),     32'(lvl));
        tick();
        chk("dis_hold", 32'(link_state), 32'd0);

        // Re-enable repeats the full training.
        txen = 1'b1;
        tick();
        chk("re_state", 32'(link_state), 32'd1);
        chk("re_phase", 32'(phase_out),  32'd0);
        chk("re_txd",   32'(serial_txd), 32'hFF);
        repeat (31) tick();
        chk("re_still_train", 32'(link_state), 32'd1);
        tick();
        chk("re_run", 32'(link_state), 32'd2);
        credit_return = 1'b1;
        tick();
        credit_return = 1'b0;
        wait_start(10, n);
        repeat (R) tick();

        // Credit arithmetic and sticky overflow from a fresh reset, in IDLE.
        txen = 1'b0;
        ioclk_rst = 1'b1;
        tick();
        ioclk_rst = 1'b0;
        chk("ca_start", 32'(credit_cnt), 32'd4);
        for (int i = 0; i < 13; i++) begin
            credit_return = ctab[i].ret;
            tick();
            chk("ca_cnt", 32'(credit_cnt), 32'(ctab[i].cnt));
            chk("ca_ovf", 32'(credit_ovf), 32'(ctab[i].ovf));
        end
        credit_return = 1'b0;

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
